// File: rtl/cic_interp_filter.sv
// cic_interp_filter: N-stage CIC interpolator.
// Low-rate samples are accepted once every RATE clocks through din_valid/din_ready.
// They pass through N pipelined combs, are zero-stuffed by RATE, and then run through
// N integrators at the full clock rate. One output sample is produced on every clock.
// Optional build macro CIC_INTERP_ROUND_EN: when defined, the output is rounded half-up.
// When it is not defined, the output is truncated (arithmetic shift).
//
// Handshake: din is taken on a posedge when din_ready=1. din_ready is high exactly
// when the phase counter is 0, so it is high on 1 clock in RATE. If din_valid is low
// on that edge, a zero sample is used instead and the sticky underrun flag is set.
// The pipeline never stalls. din_valid on any other edge is ignored.
module cic_interp_filter #(
  parameter int WIDTH_IN  = 16,
  parameter int WIDTH_OUT = 16,
  parameter int RATE      = 8,
  parameter int STAGES    = 3,
  parameter int DELAY     = 1
) (
  input  logic                 clk,
  input  logic                 reset_b,
  input  logic [WIDTH_IN-1:0]  din,
  input  logic                 din_valid,
  output logic                 din_ready,
  output logic [WIDTH_OUT-1:0] dout,
  output logic                 dout_valid,
  output logic                 underrun
);

  localparam int W_INT = WIDTH_IN + STAGES * $clog2(RATE * DELAY);
  localparam int SHIFT = W_INT - WIDTH_OUT;
  localparam int PW    = $clog2(RATE);
  localparam int VPW   = 2 * STAGES + 2;
  localparam logic [PW-1:0] PHASE_LAST = PW'(RATE - 1);

  logic [PW-1:0]           phase_q, phase_d;
  logic                    underrun_q, underrun_d;
  logic signed [W_INT-1:0] x_q, x_d;
  logic [STAGES:0]         stb_q, stb_d;
  logic signed [W_INT-1:0] comb_q [STAGES];
  logic signed [W_INT-1:0] comb_d [STAGES];
  logic signed [W_INT-1:0] comb_in [STAGES];
  logic signed [W_INT-1:0] dly_q [STAGES][DELAY];
  logic signed [W_INT-1:0] dly_d [STAGES][DELAY];
  logic signed [W_INT-1:0] up_q, up_d;
  logic signed [W_INT-1:0] integ_q [STAGES];
  logic signed [W_INT-1:0] integ_d [STAGES];
  logic [VPW-1:0]          vpipe_q, vpipe_d;
  logic                    dout_valid_q, dout_valid_d;
  logic [WIDTH_OUT-1:0]    dout_q, dout_d;
  logic [WIDTH_OUT-1:0]    scaled;
  logic                    slot, accept;

  assign slot      = (phase_q == '0);
  assign accept    = slot & din_valid;
  assign din_ready = slot;

  assign dout       = dout_q;
  assign dout_valid = dout_valid_q;
  assign underrun   = underrun_q;

  // Comb inputs: stage 1 takes the captured sample, and each later stage takes the previous comb.
  assign comb_in[0] = x_q;
  for (genvar g = 1; g < STAGES; g++) begin : g_cin
    assign comb_in[g] = comb_q[g-1];
  end

  // Output scaling: keep the top WIDTH_OUT bits of the last integrator.
`ifdef CIC_INTERP_ROUND_EN
  if (SHIFT > 0) begin : g_round
    localparam logic [W_INT:0] HALF = (W_INT + 1)'(1) << (SHIFT - 1);
    assign scaled = WIDTH_OUT'(({integ_q[STAGES-1][W_INT-1], integ_q[STAGES-1]} + HALF) >> SHIFT);
  end else begin : g_noround
    assign scaled = WIDTH_OUT'(integ_q[STAGES-1]);
  end
`else
  assign scaled = WIDTH_OUT'(integ_q[STAGES-1] >>> SHIFT);
`endif

  // Next-state logic: phase, sample capture, strobed combs, zero-stuffing, integrators, output.
  always_comb begin
    phase_d    = (phase_q == PHASE_LAST) ? '0 : phase_q + PW'(1);
    underrun_d = underrun_q | (slot & ~din_valid);

    x_d = x_q;
    if (slot) begin
      x_d = din_valid ? {{(W_INT - WIDTH_IN){din[WIDTH_IN-1]}}, din} : '0;
    end

    // The slot pulse walks down this register and enables one comb per clock.
    stb_d = {stb_q[STAGES-1:0], slot};

    comb_d = comb_q;
    dly_d  = dly_q;
    for (int i = 0; i < STAGES; i++) begin
      if (stb_q[i]) begin
        comb_d[i]   = comb_in[i] - dly_q[i][DELAY-1];
        dly_d[i][0] = comb_in[i];
        for (int j = 1; j < DELAY; j++) begin
          dly_d[i][j] = dly_q[i][j-1];
        end
      end
    end

    // Zero-stuffing: the last comb output is taken for one clock, and zero is used on all other clocks.
    up_d = stb_q[STAGES] ? comb_q[STAGES-1] : '0;

    // Integrators run on every clock. Wrap-around is intended because the combs cancel it.
    integ_d[0] = integ_q[0] + up_q;
    for (int i = 1; i < STAGES; i++) begin
      integ_d[i] = integ_q[i] + integ_q[i-1];
    end

    // Bit 0 sticks once a sample is accepted. The top bit marks when that sample reaches dout.
    vpipe_d      = {vpipe_q[VPW-2:0], vpipe_q[0] | accept};
    dout_valid_d = vpipe_q[VPW-1];
    dout_d       = vpipe_q[VPW-1] ? scaled : '0;
  end

  // State registers with synchronous active-low clear of everything in flight.
  always_ff @(posedge clk) begin
    if (!reset_b) begin
      phase_q      <= '0;
      underrun_q   <= 1'b0;
      x_q          <= '0;
      stb_q        <= '0;
      up_q         <= '0;
      vpipe_q      <= '0;
      dout_valid_q <= 1'b0;
      dout_q       <= '0;
      for (int i = 0; i < STAGES; i++) begin
        comb_q[i]  <= '0;
        integ_q[i] <= '0;
        for (int j = 0; j < DELAY; j++) begin
          dly_q[i][j] <= '0;
        end
      end
    end else begin
      phase_q      <= phase_d;
      underrun_q   <= underrun_d;
      x_q          <= x_d;
      stb_q        <= stb_d;
      up_q         <= up_d;
      vpipe_q      <= vpipe_d;
      dout_valid_q <= dout_valid_d;
      dout_q       <= dout_d;
      comb_q       <= comb_d;
      integ_q      <= integ_d;
      dly_q        <= dly_d;
    end
  end

endmodule

// File: tb/tb_cic_interp_filter.sv
// Testbench for cic_interp_filter with the default parameters.
// The reference model treats the filter as a convolution. Each accepted low-rate sample,
// stuffed by RATE, is convolved with the CIC impulse response ((1-z^-RD)/(1-z^-1))^N.
// The sum wraps at W_INT bits and is then scaled. It is checked against the outputs on
// every clock. Literal expectations pin the model.
module tb_cic_interp_filter;

  localparam int WIDTH_IN  = 16;
  localparam int WIDTH_OUT = 16;
  localparam int RATE      = 8;
  localparam int STAGES    = 3;
  localparam int DELAY     = 1;
  localparam int RD        = RATE * DELAY;
  localparam int W_INT     = WIDTH_IN + STAGES * $clog2(RD);
  localparam int S         = W_INT - WIDTH_OUT;
  localparam int HL        = STAGES * (RD - 1) + 1;
  localparam int LAT       = 2 * STAGES + 2;

  logic                        clk;
  logic                        reset_b;
  logic signed [WIDTH_IN-1:0]  din;
  logic                        din_valid;
  logic                        din_ready;
  logic [WIDTH_OUT-1:0]        dout;
  logic                        dout_valid;
  logic                        underrun;

  int tests;
  int fails;
  int dout_log[$];

  cic_interp_filter #(
    .WIDTH_IN (WIDTH_IN),
    .WIDTH_OUT(WIDTH_OUT),
    .RATE     (RATE),
    .STAGES   (STAGES),
    .DELAY    (DELAY)
  ) dut (
    .clk       (clk),
    .reset_b   (reset_b),
    .din       (din),
    .din_valid (din_valid),
    .din_ready (din_ready),
    .dout      (dout),
    .dout_valid(dout_valid),
    .underrun  (underrun)
  );

  // Clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Reference model state
  longint h[64];
  longint xq[$];
  int     k;
  int     first_k;
  bit     und_m;
  bit     armed;

  function automatic logic [WIDTH_OUT-1:0] model_out(int n);
    longint acc;
    logic signed [63:0] accv;
    logic signed [W_INT-1:0] vt;
    logic signed [W_INT:0] r;
    acc = 0;
    for (int m = n / RATE; m >= 0; m--) begin
      int j;
      j = n - m * RATE;
      if (j >= HL) break;
      if (m < xq.size()) acc += xq[m] * h[j];
    end
    accv = acc;
    vt = accv[W_INT-1:0];
`ifdef CIC_INTERP_ROUND_EN
    r = {vt[W_INT-1], vt} + (W_INT + 1)'(longint'(1) << (S - 1));
    r = r >>> S;
`else
    r = {vt[W_INT-1], vt} >>> S;
`endif
    return r[WIDTH_OUT-1:0];
  endfunction

  // Scoreboard: update the model at each posedge, then compare all outputs 1ns later.
  initial begin : model_compare
    longint t[64];
    int len;
    logic [WIDTH_OUT-1:0] exp_dout;
    logic exp_valid, exp_ready;
    for (int i = 0; i < 64; i++) h[i] = 0;
    h[0] = 1;
    len = 1;
    for (int s = 0; s < STAGES; s++) begin
      for (int i = 0; i < 64; i++) t[i] = 0;
      for (int i = 0; i < len; i++)
        for (int j = 0; j < RD; j++) t[i + j] += h[i];
      len += RD - 1;
      for (int i = 0; i < 64; i++) h[i] = t[i];
    end
    armed = 0;
    forever begin
      @(posedge clk);
      if (!reset_b) begin
        armed = 1;
        k = -1;
        xq.delete();
        first_k = -1;
        und_m = 0;
      end else if (armed) begin
        k++;
        if (k % RATE == 0) begin
          if (din_valid) begin
            xq.push_back(longint'(din));
            if (first_k < 0) first_k = k;
          end else begin
            xq.push_back(0);
            und_m = 1;
          end
        end
      end
      #1;
      if (armed) begin
        if (k < 0) begin
          exp_ready = 1'b1;
          exp_valid = 1'b0;
          exp_dout  = '0;
        end else begin
          exp_ready = ((k + 1) % RATE == 0);
          exp_valid = (first_k >= 0) && (k >= first_k + LAT);
          exp_dout  = exp_valid ? model_out(k - LAT) : '0;
        end
        tests++;
        if (dout !== exp_dout || dout_valid !== exp_valid || din_ready !== exp_ready ||
            underrun !== und_m) begin
          fails++;
          $display("FAIL cycle_check k=%0d: dout=%0d exp %0d valid=%b exp %b ready=%b exp %b underrun=%b exp %b",
                   k, $signed(dout), $signed(exp_dout), dout_valid, exp_valid, din_ready, exp_ready,
                   underrun, und_m);
        end
        if (dout_valid === 1'b1) dout_log.push_back(int'($signed(dout)));
      end
    end
  end

  // Driver tasks
  task automatic check(input string name, input logic signed [31:0] act, input logic signed [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset_b   = 1'b0;
    din_valid = 1'b0;
    din       = '0;
    repeat (2) @(negedge clk);
    check("rst_dout", $signed(dout), 0);
    check("rst_dout_valid", {31'b0, dout_valid}, 0);
    check("rst_underrun", {31'b0, underrun}, 0);
    check("rst_din_ready", {31'b0, din_ready}, 1);
    reset_b = 1'b1;
    dout_log.delete();
  endtask

  // Present one sample (or a dropped slot when v=0) and return just after its slot edge.
  task automatic send(input logic v, input logic signed [WIDTH_IN-1:0] d);
    int w;
    din_valid = v;
    din       = d;
    w = 0;
    while (din_ready !== 1'b1 && w < 4 * RATE) begin
      @(negedge clk);
      w++;
    end
    if (din_ready !== 1'b1) begin
      tests++;
      fails++;
      $display("FAIL send_timeout: din_ready=%b, required 1 within %0d clocks", din_ready, 4 * RATE);
    end
    @(negedge clk);
    din_valid = 1'b0;
  endtask

  // Stimulus
  initial begin : stimulus
    int imp_exp[8];
    int sum, nz, bad, rnd_exp;
    tests = 0;
    fails = 0;
    reset_b = 1'b0;
    din = '0;
    din_valid = 1'b0;
    imp_exp = '{1, 3, 6, 10, 15, 21, 28, 36};
`ifdef CIC_INTERP_ROUND_EN
    rnd_exp = 13;
`else
    rnd_exp = 12;
`endif

    // Reset, handshake and fill latency with a DC input of 2048
    do_reset();
    din = 16'sd2048;
    din_valid = 1'b1;
    check("ready_first_clock", {31'b0, din_ready}, 1);
    @(negedge clk);
    check("ready_after_slot", {31'b0, din_ready}, 0);
    repeat (7) @(negedge clk);
    check("valid_before_fill", {31'b0, dout_valid}, 0);
    check("dout_before_fill", $signed(dout), 0);
    check("underrun_before_fill", {31'b0, underrun}, 0);
    check("ready_period", {31'b0, din_ready}, 1);
    @(negedge clk);
    check("valid_at_fill", {31'b0, dout_valid}, 1);
    repeat (12) send(1'b1, 16'sd2048);
    bad = 0;
    for (int i = STAGES * RATE; i < dout_log.size(); i++) if (dout_log[i] != 256) bad++;
    check("dc_settled_bad_count", bad, 0);
    check("dc_log_len_ok", {31'b0, dout_log.size() > 60}, 1);
    check("dc_last", dout_log[dout_log.size() - 1], 256);
    check("dc_underrun", {31'b0, underrun}, 0);

    // Impulse of 512
    do_reset();
    send(1'b1, 16'sd512);
    repeat (8) send(1'b1, 16'sd0);
    check("imp_log_len_ok", {31'b0, dout_log.size() >= 40}, 1);
    for (int i = 0; i < 8 && i < dout_log.size(); i++) check($sformatf("imp_out%0d", i), dout_log[i], imp_exp[i]);
    sum = 0;
    nz = 0;
    for (int i = 0; i < 40 && i < dout_log.size(); i++) begin
      sum += dout_log[i];
      if (dout_log[i] != 0) nz++;
    end
    check("imp_sum", sum, 512);
    check("imp_nonzero", nz, HL);
    check("imp_tail_zero", dout_log[dout_log.size() - 1], 0);

    // Rounding with a DC input of 100 (internal value 6400)
    do_reset();
    repeat (8) send(1'b1, 16'sd100);
    check("round_dc", dout_log[dout_log.size() - 1], rnd_exp);

    // Dropped slot
    send(1'b0, 16'sd100);
    check("underrun_set", {31'b0, underrun}, 1);
    repeat (4) send(1'b1, 16'sd100);
    check("underrun_sticky", {31'b0, underrun}, 1);
    check("underrun_recovered", dout_log[dout_log.size() - 1], rnd_exp);

    // Reset for a single clock in mid-stream
    din = 16'sd100;
    din_valid = 1'b1;
    repeat (3) @(negedge clk);
    reset_b = 1'b0;
    @(negedge clk);
    check("midrst_dout", $signed(dout), 0);
    check("midrst_valid", {31'b0, dout_valid}, 0);
    check("midrst_underrun", {31'b0, underrun}, 0);
    reset_b = 1'b1;
    dout_log.delete();
    repeat (5) send(1'b1, 16'sd0);
    nz = 0;
    for (int i = 0; i < dout_log.size(); i++) if (dout_log[i] != 0) nz++;
    check("midrst_no_residue", nz, 0);
    check("midrst_valid_again", {31'b0, dout_valid}, 1);

    // Full-scale alternating input (integrator wrap-around)
    do_reset();
    for (int i = 0; i < 1000; i++) send(1'b1, (i % 2) ? 16'sd32767 : -16'sd32768);
    check("wrap_underrun", {31'b0, underrun}, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
